// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiply is radix-2 shift-add on operand magnitudes. Divide is radix-2 restoring
// division. Results are sign-corrected on the final iteration. Divide-by-zero and
// signed overflow bypass the iteration and finish one cycle after accept.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int            CW    = $clog2(XLEN + 1);
    localparam logic [CW-1:0] ITERS = CW'(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;

    // Latched operation context. hi/lo form one 2*XLEN working register:
    // for multiply it is {partial product, remaining multiplier bits},
    // for divide it is {partial remainder, dividend/quotient bits}.
    logic [2:0]      funct_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic            neg_q;
    logic [CW-1:0]   cnt_q;

    // Operand decode for the accept cycle
    logic            a_signed, b_signed, a_neg, b_neg;
    logic            div_zero, div_ovf, special, accept;
    logic [XLEN-1:0] a_mag, b_mag, special_val;

    // Iteration datapath
    logic [XLEN:0]     sum, shifted, diff;
    logic              borrow;
    logic [XLEN-1:0]   hi_nxt, lo_nxt, quot_rem, final_val;
    logic [2*XLEN-1:0] prod, prod_s;

    // Decode signedness, magnitudes and the special divide cases from the live inputs
    always_comb begin
        // NOTE: every always_comb output is assigned first so no path can infer a latch.
        a_signed    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg       = a_signed & op_a[XLEN-1];
        b_neg       = b_signed & op_b[XLEN-1];
        a_mag       = a_neg ? -op_a : op_a;
        b_mag       = b_neg ? -op_b : op_b;
        div_zero    = funct3[2] && (op_b == '0);
        div_ovf     = funct3[2] && !funct3[0] &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        special     = div_zero || div_ovf;
        special_val = '0;
        if (div_zero)
            special_val = funct3[1] ? op_a : '1;
        else if (div_ovf)
            special_val = funct3[1] ? '0 : op_a;
        accept      = (state == IDLE) && start && !flush;
    end

    // One shift-add or restoring-divide step, plus sign-corrected final selection
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        borrow  = diff[XLEN];
        if (funct_q[2]) begin
            hi_nxt = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            lo_nxt = {lo_q[XLEN-2:0], ~borrow};
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo_q[XLEN-1:1]};
        end
        prod     = {hi_nxt, lo_nxt};
        prod_s   = neg_q ? -prod : prod;
        quot_rem = funct_q[1] ? hi_nxt : lo_nxt;
        if (funct_q[2])
            final_val = neg_q ? -quot_rem : quot_rem;
        else if (funct_q[1:0] == 2'b00)
            final_val = prod_s[XLEN-1:0];
        else
            final_val = prod_s[2*XLEN-1:XLEN];
    end

    // Next-state logic; flush overrides everything and returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = special ? DONE : CALC;
            CALC:    if (cnt_q == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Operand latch, iteration registers and registered result/rd
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct_q <= '0;
            rd_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else if (!flush) begin
            if (accept) begin
                funct_q <= funct3;
                rd_q    <= rd_in;
                hi_q    <= '0;
                lo_q    <= a_mag;
                b_q     <= b_mag;
                neg_q   <= (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);
                cnt_q   <= ITERS;
                if (special) begin
                    result <= special_val;
                    rd_out <= rd_in;
                end
            end else if (state == CALC) begin
                hi_q  <= hi_nxt;
                lo_q  <= lo_nxt;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result <= final_val;
                    rd_out <= rd_q;
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M cases, special divides,
// flush/reset aborts, start held through an op, plus a few model-checked random ops.
module tb_mul_div_unit;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_assert   = 0;
    int          n_fail     = 0;
    int          push_total = 0;
    int          done_total = 0;
    int          busy_gap   = 0;
    logic [31:0] last_exp   = '0;
    logic [4:0]  last_rd    = '0;

    mul_div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, required finish before 100000 time units");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model using native 64-bit / signed arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        ea, eb, p;
        logic signed [31:0] sa, sb_;
        sa  = a;
        sb_ = b;
        ea  = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        eb  = (f == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p   = ea * eb;
        case (f)
            3'd0:    return p[31:0];
            3'd1,
            3'd2,
            3'd3:    return p[63:32];
            3'd4:    if (b == 0) return 32'hFFFF_FFFF;
                     else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                     else return sa / sb_;
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    if (b == 0) return a;
                     else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                     else return sa % sb_;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Scoreboard consumer: every done pulse pops and compares one expected entry
    always @(negedge clk) begin
        if (!rst && done) begin
            done_total++;
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_done: observed done=1 with no pending op, expected done=0");
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.res);
                check("rd_out", 32'(rd_out), 32'(mon_e.rd));
            end
        end
    end

    // Called just after the accept edge (cycle 1); returns done cycle, 0 on timeout.
    // Leaves time at the negedge of the done cycle.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (!busy) busy_gap++;
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one op from IDLE (time = just after a posedge), push its expectation and wait for it
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int lat;
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        sb.push_back('{res: exp, rd: rd});
        push_total++;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
        rd_in  = ~rd;
        funct3 = ~f;
        busy_gap = 0;
        wait_done(lat);
        check({tag, "_done_cycle"}, 32'(lat), 32'(exp_lat(f, a, b)));
        check({tag, "_busy_before_done"}, 32'(busy_gap), 32'd0);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_idle_after"}, {30'b0, busy, done}, 32'd0);
        last_exp = exp;
        last_rd  = rd;
    endtask

    initial begin
        int          lat;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, rd_out, 25'b0}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Multiply family
        do_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
        do_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE);
        do_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         5'd8, 32'hFFFF_FFFF);

        // Divide family, rd=0 computed normally
        do_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9,  32'hFFFF_FFFD);
        do_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF);
        do_op("divu",   3'd5, 32'd100,       32'd7, 5'd11, 32'd14);
        do_op("remu",   3'd7, 32'd100,       32'd7, 5'd0,  32'd2);

        // Special cases finishing in cycle 1
        do_op("divu_by0", 3'd5, 32'd12345,     32'd0,         5'd12, 32'hFFFF_FFFF);
        do_op("rem_by0",  3'd6, 32'd5,         32'd0,         5'd13, 32'd5);
        do_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000);
        do_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0);

        // Random ops against the model
        for (int i = 0; i < 8; i++) begin
            rf = 3'(i);
            ra = $urandom;
            rb = (i == 5) ? 32'($urandom_range(1, 15)) : $urandom;
            do_op("rand", rf, ra, rb, 5'(16 + i), model(rf, ra, rb));
        end
        do_op("divu_known", 3'd5, 32'd1000, 32'd9, 5'd3, 32'd111);

        // Flush during cycle 10 of a DIV: no done, result/rd_out untouched
        funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd30; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy_c11", {30'b0, busy, done}, 32'd0);
        // flush in IDLE with start=1 rejects the start
        start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_rejects_start", 32'(busy), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("flush_result_kept", result, last_exp);
        check("flush_rd_kept", 32'(rd_out), 32'(last_rd));

        // Reset mid-MUL clears outputs immediately, no done follows
        funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; rd_in = 5'd31; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("rst_mid_flags", {busy, done, rd_out, 25'b0}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        #2;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("rst_no_done", 32'(busy), 32'd0);

        // start held through an op and its DONE cycle: one done, then back-to-back accept
        funct3 = 3'd0; op_a = 32'd123; op_b = 32'd456; rd_in = 5'd20; start = 1'b1;
        sb.push_back('{res: 32'd56088, rd: 5'd20});
        push_total++;
        @(posedge clk);
        #1;
        wait_done(lat);
        check("held_done_cycle", 32'(lat), 32'd33);
        funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd9; rd_in = 5'd21;
        sb.push_back('{res: 32'd111, rd: 5'd21});
        push_total++;
        @(posedge clk);
        #1;
        check("held_idle_cycle", {30'b0, busy, done}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        check("b2b_done_cycle", 32'(lat), 32'd33);
        @(posedge clk);
        #1;
        check("b2b_idle_after", 32'(busy), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("done_count", 32'(done_total), 32'(push_total));
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
